// File: rtl/icache_dm_param_if.sv
// Fetch/bus-side signal bundle for icache_dm_param. The flush wire exists only when
// ICACHE_FLUSH_EN is defined.
interface icache_dm_param_if #(
  parameter int LINE_BYTES = 32,
  parameter int NUM_SETS   = 16,
  parameter int TAG_W      = 6
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;

  logic              ren;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              ic_exp;
  logic [LINE_W-1:0] r_data;
  logic              ic_hit;
  logic              ic_miss;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_fill_data;
`ifdef ICACHE_FLUSH_EN
  logic              flush;

  modport master (output ren, index, tag, ic_exp, mem_ack, mem_fill_data, flush,
                  input  r_data, ic_hit, ic_miss, mem_req, mem_addr);
  modport slave  (input  ren, index, tag, ic_exp, mem_ack, mem_fill_data, flush,
                  output r_data, ic_hit, ic_miss, mem_req, mem_addr);
`else
  modport master (output ren, index, tag, ic_exp, mem_ack, mem_fill_data,
                  input  r_data, ic_hit, ic_miss, mem_req, mem_addr);
  modport slave  (input  ren, index, tag, ic_exp, mem_ack, mem_fill_data,
                  output r_data, ic_hit, ic_miss, mem_req, mem_addr);
`endif
endinterface

// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with a single-outstanding-miss refill FSM.
// Optional ICACHE_FLUSH_EN adds a whole-cache invalidate (deferred while a miss is in flight).
module icache_dm_param #(
  parameter int LINE_BYTES = 32,
  parameter int NUM_SETS   = 16,
  parameter int TAG_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  icache_dm_param_if.slave   bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

  state_t              r_state;
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tags  [NUM_SETS];
  logic [LINE_W-1:0]   r_lines [NUM_SETS];
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
`ifdef ICACHE_FLUSH_EN
  logic                r_flush_pend;
`endif

  logic              w_hit;
  logic              w_idle;
  logic              w_start;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;

  assign w_hit      = r_valid[bus.index] && (r_tags[bus.index] == bus.tag);
  assign w_idle     = (r_state == S_IDLE);
  assign w_start    = w_idle && bus.ren && !w_hit && !bus.ic_exp;
  // The refill target comes only from the latched request address.
  assign w_fill_idx = r_mem_addr[OFF_W +: IDX_W];
  assign w_fill_tag = r_mem_addr[ADDR_W-1 -: TAG_W];

  assign bus.r_data   = r_lines[bus.index];
  assign bus.ic_hit   = bus.ren && w_hit && w_idle;
  assign bus.ic_miss  = w_idle ? (bus.ren && !bus.ic_exp && !w_hit) : 1'b1;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // Line storage carries no reset; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (r_state == S_REQ && bus.mem_ack) begin
      r_lines[w_fill_idx] <= bus.mem_fill_data;
      r_tags[w_fill_idx]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
`ifdef ICACHE_FLUSH_EN
      r_flush_pend <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
          if (bus.flush) r_valid <= '0;
`endif
          if (w_start) begin
            r_mem_addr <= {bus.tag, bus.index, {OFF_W{1'b0}}};
            r_mem_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef ICACHE_FLUSH_EN
          if (bus.flush) r_flush_pend <= 1'b1;
`endif
          if (bus.mem_ack) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_req           <= 1'b0;
            r_state             <= S_FILL;
          end
        end
        S_FILL: begin
          // A flush seen during the miss also kills the line just written.
`ifdef ICACHE_FLUSH_EN
          if (bus.flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
